// File: rtl/ap_ctrl_perf_monitor.sv
// HLS ap_ctrl handshake monitor: per-channel txn count, last/max latency, stall.
// Define APMON_STALL_CNT_EN to build the DONE_WAIT stall counters.
module ap_ctrl_perf_monitor #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              clear,
  input  logic              finish,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [1:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] busy,
  output logic              all_idle
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DWAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAXV = '1;

  state_t           r_state  [NUM_CH];
  state_t           w_nstate [NUM_CH];
  logic [CNT_W-1:0] r_cur    [NUM_CH];
  logic [CNT_W-1:0] w_cur    [NUM_CH];
  logic [CNT_W-1:0] r_txn    [NUM_CH];
  logic [CNT_W-1:0] w_txn    [NUM_CH];
  logic [CNT_W-1:0] r_last   [NUM_CH];
  logic [CNT_W-1:0] w_last   [NUM_CH];
  logic [CNT_W-1:0] r_max    [NUM_CH];
  logic [CNT_W-1:0] w_max    [NUM_CH];
  logic [CNT_W-1:0] w_lat    [NUM_CH];
  logic [NUM_CH-1:0] w_done;
  logic [NUM_CH-1:0] w_idle_n;
  logic [CNT_W-1:0] w_rd;
  logic             r_all_idle;
`ifdef APMON_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall  [NUM_CH];
  logic [CNT_W-1:0] w_stall  [NUM_CH];
`endif

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == MAXV) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_nstate[i] = r_state[i];
      w_cur[i]    = r_cur[i];
      w_txn[i]    = r_txn[i];
      w_last[i]   = r_last[i];
      w_max[i]    = r_max[i];
      w_lat[i]    = '0;
      w_done[i]   = 1'b0;
`ifdef APMON_STALL_CNT_EN
      w_stall[i]  = r_stall[i];
`endif
      if (clear) begin
        w_nstate[i] = S_IDLE;
        w_cur[i]    = '0;
        w_txn[i]    = '0;
        w_last[i]   = '0;
        w_max[i]    = '0;
`ifdef APMON_STALL_CNT_EN
        w_stall[i]  = '0;
`endif
      end else if (!finish) begin
        unique case (r_state[i])
          S_IDLE: begin
            if (ap_start[i]) begin
              w_cur[i] = '0;
              if (!ap_done[i])
                w_nstate[i] = S_BUSY;
              else if (ap_continue[i])
                w_done[i] = 1'b1;
              else
                w_nstate[i] = S_DWAIT;
            end
          end
          S_BUSY: begin
            if (ap_done[i]) begin
              w_lat[i] = sat_inc(r_cur[i]);
              if (ap_continue[i]) begin
                w_done[i] = 1'b1;
              end else begin
                w_nstate[i] = S_DWAIT;
                w_cur[i]    = w_lat[i];
              end
            end else begin
              w_cur[i] = sat_inc(r_cur[i]);
            end
          end
          S_DWAIT: begin
            if (ap_continue[i]) begin
              w_lat[i]  = r_cur[i];
              w_done[i] = 1'b1;
            end else begin
`ifdef APMON_STALL_CNT_EN
              w_stall[i] = sat_inc(r_stall[i]);
`endif
            end
          end
          default: w_nstate[i] = S_IDLE;
        endcase
        if (w_done[i]) begin
          w_txn[i]  = sat_inc(r_txn[i]);
          w_last[i] = w_lat[i];
          if (w_lat[i] > r_max[i])
            w_max[i] = w_lat[i];
          // a completion out of BUSY/DONE_WAIT may chain straight into the next start
          if (r_state[i] != S_IDLE) begin
            w_nstate[i] = ap_start[i] ? S_BUSY : S_IDLE;
            w_cur[i]    = '0;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i]     = (r_state[i] != S_IDLE);
      w_idle_n[i] = (w_nstate[i] == S_IDLE);
    end
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        case (rd_sel)
          2'd0: w_rd = r_txn[i];
          2'd1: w_rd = r_last[i];
          2'd2: w_rd = r_max[i];
`ifdef APMON_STALL_CNT_EN
          default: w_rd = r_stall[i];
`else
          default: w_rd = '0;
`endif
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= S_IDLE;
        r_cur[i]   <= '0;
        r_txn[i]   <= '0;
        r_last[i]  <= '0;
        r_max[i]   <= '0;
`ifdef APMON_STALL_CNT_EN
        r_stall[i] <= '0;
`endif
      end
      rd_data    <= '0;
      r_all_idle <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_nstate[i];
        r_cur[i]   <= w_cur[i];
        r_txn[i]   <= w_txn[i];
        r_last[i]  <= w_last[i];
        r_max[i]   <= w_max[i];
`ifdef APMON_STALL_CNT_EN
        r_stall[i] <= w_stall[i];
`endif
      end
      rd_data    <= w_rd;
      r_all_idle <= &w_idle_n;
    end
  end

  assign all_idle = r_all_idle;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Bench for ap_ctrl_perf_monitor: vector table of transactions plus
// hand sequences for back-to-back, clear, freeze and async reset.
module tb_ap_ctrl_perf_monitor;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;
`ifdef APMON_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;
  logic              clear;
  logic              finish;
  logic [CH_W-1:0]   rd_ch;
  logic [1:0]        rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] busy;
  logic              all_idle;

  ap_ctrl_perf_monitor #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .ap_continue(ap_continue),
    .clear      (clear),
    .finish     (finish),
    .rd_ch      (rd_ch),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .busy       (busy),
    .all_idle   (all_idle)
  );

  always #5 clock = ~clock;

  typedef struct {
    int ch;
    int lat;
    int stall;
    int txn;
    int last;
    int mx;
    int stl;
  } vec_t;

  typedef struct {
    int    exp;
    string name;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sb_push(input int exp, input string name);
    sb_t e;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop();
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk(e.name, int'(rd_data), e.exp);
    end
  endtask

  task automatic rd(input int ch, input int sel, input int exp, input string nm);
    rd_ch  = CH_W'(ch);
    rd_sel = 2'(sel);
    sb_push(exp, $sformatf("%s ch%0d sel%0d", nm, ch, sel));
    tick();
    sb_pop();
  endtask

  task automatic do_clear(input logic [NUM_CH-1:0] st);
    clear    = 1'b1;
    ap_start = st;
    tick();
    clear    = 1'b0;
    ap_start = '0;
  endtask

  task automatic do_txn(input int ch, input int lat, input int stall);
    ap_start[ch]    = 1'b1;
    ap_done[ch]     = (lat == 0);
    ap_continue[ch] = (lat != 0) || (stall == 0);
    tick();
    ap_start[ch] = 1'b0;
    ap_done[ch]  = 1'b0;
    chk($sformatf("busy_after_start ch%0d", ch), int'(busy[ch]),
        (lat == 0 && stall == 0) ? 0 : 1);
    if (lat > 0) begin
      repeat (lat - 1) tick();
      ap_done[ch]     = 1'b1;
      ap_continue[ch] = (stall == 0);
      tick();
      ap_done[ch] = 1'b0;
    end
    if (stall > 0) begin
      ap_continue[ch] = 1'b0;
      repeat (stall) tick();
      ap_continue[ch] = 1'b1;
      tick();
    end
    ap_continue[ch] = 1'b1;
    chk($sformatf("busy_after_done ch%0d", ch), int'(busy[ch]), 0);
    chk("all_idle_after_done", int'(all_idle), 1);
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{0,   7, 0, 1,   7,   7, 0};
    vt[1] = '{0,   3, 0, 2,   3,   7, 0};
    vt[2] = '{1,   1, 0, 1,   1,   1, 0};
    vt[3] = '{2,   5, 4, 1,   5,   5, 4};
    vt[4] = '{3,   0, 0, 1,   0,   0, 0};
    vt[5] = '{3,   0, 2, 2,   0,   0, 2};
    vt[6] = '{0,  12, 1, 3,  12,  12, 1};
    vt[7] = '{1, 300, 0, 2, 255, 255, 0};
    vt[8] = '{1,   2, 0, 3,   2, 255, 0};

    reset       = 1'b0;
    ap_start    = '0;
    ap_done     = '0;
    ap_continue = '1;
    clear       = 1'b0;
    finish      = 1'b0;
    rd_ch       = '0;
    rd_sel      = '0;
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_all_idle", int'(all_idle), 1);
    chk("rst_rd_data", int'(rd_data), 0);
    reset = 1'b1;
    tick();

    for (int v = 0; v < 9; v++) begin
      do_txn(vt[v].ch, vt[v].lat, vt[v].stall);
      rd(vt[v].ch, 0, vt[v].txn, $sformatf("v%0d txn", v));
      rd(vt[v].ch, 1, vt[v].last, $sformatf("v%0d last", v));
      rd(vt[v].ch, 2, vt[v].mx, $sformatf("v%0d max", v));
      rd(vt[v].ch, 3, STALL_EN ? vt[v].stl : 0, $sformatf("v%0d stall", v));
    end

    // clear with a start in the same cycle drops the start
    do_clear(4'b0100);
    chk("clear_busy", int'(busy), 0);
    chk("clear_all_idle", int'(all_idle), 1);
    for (int s = 0; s < 4; s++) begin
      rd(2, s, 0, "clr");
      rd(0, s, 0, "clr");
    end

    // back-to-back on ch1, start held high
    ap_start[1] = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("b2b_busy k%0d", k), int'(busy[1]), 1);
        tick();
      end
      ap_done[1] = 1'b1;
      if (k == 3) begin
        ap_start[1] = 1'b0;
        rd_ch  = 2'd1;
        rd_sel = 2'd0;
        sb_push(2, "b2b_pre_update_txn");
      end
      tick();
      ap_done[1] = 1'b0;
      if (k == 3) sb_pop();
      chk($sformatf("b2b_busy_done k%0d", k), int'(busy[1]), (k < 3) ? 1 : 0);
    end
    rd(1, 0, 3, "b2b txn");
    rd(1, 1, 4, "b2b last");
    rd(1, 2, 4, "b2b max");

    // freeze mid-transaction on ch0
    do_clear('0);
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    repeat (3) tick();
    finish = 1'b1;
    repeat (9) tick();
    rd(0, 0, 0, "frz_live_txn");
    chk("frz_busy", int'(busy[0]), 1);
    finish = 1'b0;
    repeat (2) tick();
    ap_done[0] = 1'b1;
    tick();
    ap_done[0] = 1'b0;
    rd(0, 0, 1, "frz txn");
    rd(0, 1, 6, "frz last");
    rd(0, 2, 6, "frz max");

    // async reset while all channels are busy
    rd_ch    = 2'd0;
    rd_sel   = 2'd1;
    ap_start = '1;
    sb_push(6, "pre_rst_last");
    tick();
    ap_start = '0;
    sb_pop();
    chk("pre_rst_busy", int'(busy), 15);
    chk("pre_rst_all_idle", int'(all_idle), 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_all_idle", int'(all_idle), 1);
    chk("arst_rd_data", int'(rd_data), 0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < 4; s++)
        rd(c, s, 0, "arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ap_ctrl_perf_monitor.md
# ap_ctrl_perf_monitor

- Synthesizable, parametrised successor to the single-module testbench status monitor.
- Observes the `ap_start`/`ap_done`/`ap_continue` handshakes of `NUM_CH` HLS modules, such as `dfr_inference` and its sub-processes.
- Keeps per-channel transaction counts, last and maximum latency, and done-stall cycles, readable through a registered select port.
- Sits next to the DUT in both the cosim bench and the FPGA build, so latency statistics survive on hardware where CSV dumping is unavailable.

## Interface
Parameters:
- `NUM_CH`, 4: number of monitored channels (≥1).
- `CNT_W`, 32: width of every counter and of `rd_data` (≥8).
- `CH_W`, `NUM_CH>1 ? $clog2(NUM_CH) : 1`: channel-select width (derived, not overridden).

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ap_start`  in  NUM_CH  per-channel start, sampled.
- `ap_done`  in  NUM_CH  per-channel done, sampled.
- `ap_continue`  in  NUM_CH  per-channel continue; tie high for modules without it.
- `clear`  in  1  synchronous clear of all counters and FSMs.
- `finish`  in  1  freeze: while high, no FSM or counter updates.
- `rd_ch`  in  CH_W  channel to read.
- `rd_sel`  in  2  field: 0 txn_cnt, 1 last_lat, 2 max_lat, 3 stall_cnt.
- `rd_data`  out  CNT_W  registered read data.
- `busy`  out  NUM_CH  channel is in BUSY or DONE_WAIT.
- `all_idle`  out  1  every channel is IDLE, registered.

## Operation
- Each channel has a 3-state FSM (IDLE, BUSY, DONE_WAIT) and a `cur_lat` counter.
- Latency is the number of edges from the start-sample edge to the done-sample edge.

IDLE:
- `ap_start`=1 and `ap_done`=0 → BUSY, `cur_lat`<=0.
- `ap_start`=1 and `ap_done`=1 → zero-latency transaction. With continue=1, complete with latency 0 and stay IDLE. With continue=0 → DONE_WAIT holding latency 0.
- `ap_done`=1 without `ap_start` is ignored.

BUSY:
- Each edge without done: `cur_lat`<=`cur_lat`+1.
- `ap_done`=1: latency = `cur_lat`+1.
  - If `ap_continue`=1, complete. After completing, `ap_start`=1 → BUSY with `cur_lat`<=0 (back-to-back); `ap_start`=0 → IDLE.
  - If `ap_continue`=0 → DONE_WAIT, latency held.

DONE_WAIT:
- Each edge with `ap_continue`=0: `stall_cnt`++.
- `ap_continue`=1: complete with the held latency, then apply the same next-state rule as BUSY.

Completion updates, all in the same edge:
- `txn_cnt`++.
- `last_lat`<=latency.
- `max_lat`<=max(`max_lat`, latency).

Arithmetic:
- All counters, including `cur_lat`, saturate at 2^CNT_W−1 and never wrap.
- Latency comparison is unsigned.

Priority:
- `clear` overrides `finish`, and `finish` overrides handshake events.
- When `clear` is high, all FSMs go to IDLE and all counters to 0. A start in the same cycle is dropped.
- When `finish` is high, FSMs and counters hold. Readout stays live.

Readout:
- `rd_data`<=field[`rd_sel`] of channel `rd_ch`.
- `rd_ch`≥`NUM_CH` returns 0.

## Timing
- `reset` low (asynchronous) forces:
  - all FSMs to IDLE;
  - all counters to 0;
  - `rd_data`=0, `busy`=0, `all_idle`=1.
- Deassertion is synchronised by the system reset tree. The block assumes it is synchronous to `clock`.
- Reset mid-transaction discards the transaction; no count is recorded.
- Read latency is 1 cycle: `rd_ch`/`rd_sel` sampled at edge k gives `rd_data` valid after edge k.
- A read issued in the completion edge returns the pre-update value. The following read returns the updated value.
- `busy[i]` is combinational from the channel state registers, so it is high in the cycle after the start-sample edge.
- `all_idle` is registered from the next-state values, so it is aligned with `busy`.
- Channels are fully independent. Simultaneous completions on all channels are all recorded in the same edge.

## Configuration
- `APMON_STALL_CNT_EN` defined:
  - DONE_WAIT stall counters are built.
  - `rd_sel`=3 returns `stall_cnt`.
- `APMON_STALL_CNT_EN` undefined:
  - No stall counter registers exist.
  - DONE_WAIT is still entered and exited as specified.
  - `rd_sel`=3 returns 0.

## Test plan
- **Single latency:** ch0 start at edge 10, done+continue at edge 17 → txn_cnt=1, last_lat=7, max_lat=7.
- **Back-to-back:** ch1 `ap_start` held high, done+continue at edges 5, 9, 13 → txn_cnt=3, last_lat=4, `busy[1]` never drops.
- **Stall:** ch2 done at edge 20 with continue low until edge 24 → stall_cnt=4 (0 without `APMON_STALL_CNT_EN`), last_lat includes no stall cycles.
- **Saturation:** `CNT_W`=8, latency 300 → last_lat=255, max_lat=255.
- **Clear and freeze:**
  - `finish` high mid-transaction for 10 cycles → `cur_lat` frozen, resumes after.
  - `clear` with `ap_start` in the same cycle → all fields 0, channel IDLE.
- **Async reset:** `reset` asserted between edges while 4 channels are BUSY → `busy`=0 immediately, `all_idle`=1, all reads 0.
